// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the core's load/store port (feeds the MEM leg of
// the write-back mux). One request is accepted at a time over a valid/ready
// handshake. The access is evaluated after a programmable latency, and the
// result is returned over a second valid/ready handshake.
//
// Loads are sign- or zero-extended (LB/LH/LW/LBU/LHU). Stores are byte-lane
// steered (SB/SH/SW). Misaligned, out-of-range and illegal-funct3 accesses
// are rejected with rsp_err instead of being performed.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (high only in IDLE)
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   req_funct3  RV32I funct3 of the load/store
//   rsp_valid   response present
//   rsp_ready   core accepts response
//   rsp_rdata   extended load data; 0 for stores and errors
//   rsp_err     access rejected
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h01000000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With LATENCY=1 the access is evaluated at the accepting edge, so the live
  // request is used; otherwise the copy latched at acceptance is used.
  logic        evWe;
  logic [31:0] evAddr;
  logic [31:0] evWdata;
  logic [2:0]  evF3;
  logic        evalFire;

  assign evWe    = (LATENCY == 1) ? req_we     : we_q;
  assign evAddr  = (LATENCY == 1) ? req_addr   : addr_q;
  assign evWdata = (LATENCY == 1) ? req_wdata  : wdata_q;
  assign evF3    = (LATENCY == 1) ? req_funct3 : funct3_q;

  assign evalFire = ((state_q == BUSY) && (cnt_q == 4'd1)) ||
                    ((LATENCY == 1) && (state_q == IDLE) && req_valid);

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          accErr;
  logic [31:0]   rdWord;
  logic [31:0]   shifted;
  logic [31:0]   loadData;
  logic [3:0]    byteEn;
  logic [31:0]   laneData;
  logic          memWe;

  // Decode the access: offset relative to the base wraps, so addresses below
  // BASE_ADDR land far above the array and fail the range test.
  always_comb begin
    off      = evAddr - BASE_ADDR;
    idx      = off[AW+1:2];
    rdWord   = mem_q[idx];
    shifted  = rdWord >> {off[1:0], 3'b000};
    accErr   = 1'b0;
    loadData = 32'd0;
    byteEn   = 4'b0000;
    laneData = 32'd0;

    if ({1'b0, off} >= LIMIT) begin
      accErr = 1'b1;
    end
    if ((evF3[1:0] == 2'd1) && evAddr[0]) begin
      accErr = 1'b1;
    end
    if ((evF3[1:0] == 2'd2) && (evAddr[1:0] != 2'b00)) begin
      accErr = 1'b1;
    end
    if (evWe && (evF3 > 3'd2)) begin
      accErr = 1'b1;
    end
    if (!evWe && ((evF3 == 3'b011) || (evF3 == 3'b110) || (evF3 == 3'b111))) begin
      accErr = 1'b1;
    end

    case (evF3)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  loadData = rdWord;
      3'b100:  loadData = {24'd0, shifted[7:0]};
      3'b101:  loadData = {16'd0, shifted[15:0]};
      default: loadData = 32'd0;
    endcase

    // Replicate the store data across the word so that the byte enables alone
    // select which lanes are written.
    case (evF3[1:0])
      2'd0: begin
        byteEn   = 4'b0001 << off[1:0];
        laneData = {4{evWdata[7:0]}};
      end
      2'd1: begin
        byteEn   = 4'b0011 << off[1:0];
        laneData = {2{evWdata[15:0]}};
      end
      2'd2: begin
        byteEn   = 4'b1111;
        laneData = evWdata;
      end
      default: begin
        byteEn   = 4'b0000;
        laneData = 32'd0;
      end
    endcase

    memWe = evalFire && evWe && !accErr;
  end

  // Array is not reset; a store commits only at its evaluating edge.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem_q[idx][8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      funct3_q    <= 3'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            funct3_q    <= req_funct3;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q     <= RESP;
              cnt_q       <= 4'd0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= (accErr || evWe) ? 32'd0 : loadData;
              rsp_err_q   <= accErr;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (accErr || evWe) ? 32'd0 : loadData;
            rsp_err_q   <= accErr;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Drives two responders in lockstep from the same request/response signals:
// instance A with LATENCY=2 and instance B with LATENCY=3. A transaction-level
// model (one outstanding access per instance, aged in cycles, plus a word
// array per instance) predicts req_ready, rsp_valid, rsp_rdata and rsp_err,
// and a single compare process checks both instances every cycle. Directed
// transactions with hand-computed results pin the model down.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int          LAT [2] = '{2, 3};

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_ready;

  logic        rrA, rvA, reA;
  logic [31:0] rdA;
  logic        rrB, rvB, reB;
  logic [31:0] rdB;

  int nChecks = 0;
  int nFails  = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_dutA (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rrA), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rvA), .rsp_ready(rsp_ready), .rsp_rdata(rdA), .rsp_err(reA)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_dutB (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rrB), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rvB), .rsp_ready(rsp_ready), .rsp_rdata(rdB), .rsp_err(reB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        dReady [2];
  logic        dValid [2];
  logic [31:0] dRdata [2];
  logic        dErr   [2];
  assign dReady[0] = rrA;
  assign dReady[1] = rrB;
  assign dValid[0] = rvA;
  assign dValid[1] = rvB;
  assign dRdata[0] = rdA;
  assign dRdata[1] = rdB;
  assign dErr[0]   = reA;
  assign dErr[1]   = reB;

  // Reference model state, one slot per instance.
  bit          mOut  [2];
  bit          mEval [2];
  int          mAge  [2];
  logic [31:0] mRdata[2];
  logic        mErr  [2];
  logic        mWe   [2];
  logic [31:0] mAddr [2];
  logic [31:0] mWdata[2];
  logic [2:0]  mF3   [2];
  logic [31:0] mm [2][DEPTH];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compute an access outcome directly from the load/store rules.
  task automatic evalModel(input int k);
    logic [31:0] off, w;
    int          size, nbytes, lane;
    bit          bad;
    off  = mAddr[k] - BASE;
    size = int'(mF3[k][1:0]);
    bad  = 0;
    if (off >= 32'(DEPTH * 4)) bad = 1;
    if (mWe[k]) begin
      if (mF3[k] > 3'd2) bad = 1;
    end else if (mF3[k] == 3'd3 || mF3[k] == 3'd6 || mF3[k] == 3'd7) begin
      bad = 1;
    end
    if (size == 1 && mAddr[k][0]) bad = 1;
    if (size == 2 && mAddr[k][1:0] != 2'b00) bad = 1;
    mEval[k] = 1;
    mErr[k]  = bad;
    mRdata[k] = 32'd0;
    if (!bad) begin
      lane = int'(off[1:0]);
      w    = mm[k][off[11:2]];
      if (mWe[k]) begin
        nbytes = 1 << size;
        for (int b = 0; b < nbytes; b++) begin
          w[(lane + b) * 8 +: 8] = mWdata[k][b * 8 +: 8];
        end
        mm[k][off[11:2]] = w;
      end else begin
        w = w >> (lane * 8);
        if (size == 0) begin
          mRdata[k] = {24'd0, w[7:0]};
          if (!mF3[k][2] && w[7]) mRdata[k] = mRdata[k] | 32'hFFFFFF00;
        end else if (size == 1) begin
          mRdata[k] = {16'd0, w[15:0]};
          if (!mF3[k][2] && w[15]) mRdata[k] = mRdata[k] | 32'hFFFF0000;
        end else begin
          mRdata[k] = w;
        end
      end
    end
  endtask

  // Model advance: an outstanding access ages one cycle per edge, is
  // evaluated once it has aged LAT-1 edges, and retires on rsp_ready.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mOut[k]  = 0;
        mEval[k] = 0;
      end else if (!mOut[k]) begin
        if (req_valid) begin
          mWe[k]    = req_we;
          mAddr[k]  = req_addr;
          mWdata[k] = req_wdata;
          mF3[k]    = req_funct3;
          mOut[k]   = 1;
          mAge[k]   = 0;
          if (LAT[k] == 1) evalModel(k);
        end
      end else if (!mEval[k]) begin
        mAge[k]++;
        if (mAge[k] == LAT[k] - 1) evalModel(k);
      end else if (rsp_ready) begin
        mOut[k]  = 0;
        mEval[k] = 0;
      end
    end
  end

  // Compare both instances against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("req_ready[%0d]", k), {31'd0, dReady[k]}, {31'd0, !mOut[k]});
        checkOutput($sformatf("rsp_valid[%0d]", k), {31'd0, dValid[k]}, {31'd0, mEval[k]});
        if (mEval[k]) begin
          checkOutput($sformatf("rsp_rdata[%0d]", k), dRdata[k], mRdata[k]);
          checkOutput($sformatf("rsp_err[%0d]", k), {31'd0, dErr[k]}, {31'd0, mErr[k]});
        end
      end
    end
  end

  // One full transaction on both instances. Returns the first response seen
  // by each and the number of cycles from acceptance until rsp_valid.
  // rsp_ready stays low for the first 'hold' cycles after acceptance.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input int hold,
                               output logic [31:0] rA, output logic eA, output int lA,
                               output logic [31:0] rB, output logic eB, output int lB);
    int n;
    bit doneA, doneB;
    @(negedge clk);
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    req_valid  = 1'b1;
    rsp_ready  = (hold == 0);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    n = 0; doneA = 0; doneB = 0; lA = -1; lB = -1;
    rA = 32'hX; rB = 32'hX; eA = 1'bX; eB = 1'bX;
    while (!(doneA && doneB) && n < 40) begin
      @(negedge clk);
      n++;
      rsp_ready = (n > hold);
      if (rvA && lA < 0) begin lA = n; rA = rdA; eA = reA; end
      if (rvB && lB < 0) begin lB = n; rB = rdB; eB = reB; end
      if (rvA && rsp_ready) doneA = 1;
      if (rvB && rsp_ready) doneB = 1;
    end
    if (!doneA) checkOutput("timeout_A", 32'd0, 32'd1);
    if (!doneB) checkOutput("timeout_B", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expectBoth(input string name, input logic [31:0] rA, input logic eA,
                            input logic [31:0] rB, input logic eB,
                            input logic [31:0] expData, input logic expErr);
    checkOutput({name, "_rdataA"}, rA, expData);
    checkOutput({name, "_rdataB"}, rB, expData);
    checkOutput({name, "_errA"}, {31'd0, eA}, {31'd0, expErr});
    checkOutput({name, "_errB"}, {31'd0, eB}, {31'd0, expErr});
  endtask

  initial begin
    logic [31:0] rA, rB, a;
    logic        eA, eB;
    int          lA, lB, sel;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_funct3 = 3'd0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_readyA", {31'd0, rrA}, 32'd1);
    checkOutput("reset_rsp_validA", {31'd0, rvA}, 32'd0);
    checkOutput("reset_rsp_rdataB", rdB, 32'd0);
    checkOutput("reset_rsp_errB", {31'd0, reB}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] filling words 0..31 with known data");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, BASE + 32'(i * 4), 32'hA5000000 | 32'(i), 3'b010, 0,
                    rA, eA, lA, rB, eB, lB);
    end

    $display("[TB] store/load basics");
    applyStimulus(1'b1, 32'h01000010, 32'hDEADBEEF, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("sw", rA, eA, rB, eB, 32'd0, 1'b0);
    checkOutput("sw_latencyA", 32'(lA), 32'd2);
    checkOutput("sw_latencyB", 32'(lB), 32'd3);
    applyStimulus(1'b0, 32'h01000010, 32'd0, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lw", rA, eA, rB, eB, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 32'h01000013, 32'd0, 3'b000, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lb", rA, eA, rB, eB, 32'hFFFFFFDE, 1'b0);
    applyStimulus(1'b0, 32'h01000013, 32'd0, 3'b100, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lbu", rA, eA, rB, eB, 32'h000000DE, 1'b0);
    applyStimulus(1'b0, 32'h01000010, 32'd0, 3'b001, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lh", rA, eA, rB, eB, 32'hFFFFBEEF, 1'b0);
    applyStimulus(1'b0, 32'h01000012, 32'd0, 3'b101, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lhu", rA, eA, rB, eB, 32'h0000DEAD, 1'b0);
    applyStimulus(1'b1, 32'h01000011, 32'hAABBCC55, 3'b000, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("sb", rA, eA, rB, eB, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'h01000010, 32'd0, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lw_after_sb", rA, eA, rB, eB, 32'hDEAD55EF, 1'b0);

    $display("[TB] rejected accesses");
    applyStimulus(1'b0, 32'h01000002, 32'd0, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lw_misaligned", rA, eA, rB, eB, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h01000001, 32'h0000FFFF, 3'b001, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("sh_misaligned", rA, eA, rB, eB, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h00FFFFFC, 32'd0, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lw_below_base", rA, eA, rB, eB, 32'd0, 1'b1);
    applyStimulus(1'b0, BASE + 32'(4 * DEPTH), 32'd0, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("lw_past_end", rA, eA, rB, eB, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h01000010, 32'd0, 3'b011, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("load_f3_011", rA, eA, rB, eB, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h01000000, 32'd0, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    expectBoth("word0_untouched", rA, eA, rB, eB, 32'hA5000000, 1'b0);

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 32'h01000010, 32'd0, 3'b010, 7, rA, eA, lA, rB, eB, lB);
    expectBoth("lw_backpressure", rA, eA, rB, eB, 32'hDEAD55EF, 1'b0);

    $display("[TB] reset one cycle after accepting a store");
    @(negedge clk);
    req_we     = 1'b1;
    req_addr   = 32'h01000020;
    req_wdata  = 32'h12345678;
    req_funct3 = 3'b010;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_readyA", {31'd0, rrA}, 32'd1);
    checkOutput("rst_req_readyB", {31'd0, rrB}, 32'd1);
    checkOutput("rst_rsp_validA", {31'd0, rvA}, 32'd0);
    checkOutput("rst_rsp_validB", {31'd0, rvB}, 32'd0);
    checkOutput("rst_rsp_rdataA", rdA, 32'd0);
    checkOutput("rst_rsp_rdataB", rdB, 32'd0);
    checkOutput("rst_rsp_errA", {31'd0, reA}, 32'd0);
    checkOutput("rst_rsp_errB", {31'd0, reB}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // A (latency 2) had already evaluated its store; B had not.
    applyStimulus(1'b0, 32'h01000020, 32'd0, 3'b010, 0, rA, eA, lA, rB, eB, lB);
    checkOutput("lw_after_reset_A", rA, 32'h12345678);
    checkOutput("lw_after_reset_B", rB, 32'hA5000008);

    $display("[TB] randomized accesses");
    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else if (sel == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else               a = BASE + 32'($urandom_range(0, 127));
      applyStimulus(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 4), rA, eA, lA, rB, eB, lB);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core's load/store port. It feeds the `MEM` leg of the write-back mux.
- Accepts one request at a time over a valid/ready handshake.
- Performs byte-lane steering for SB/SH/SW and sign/zero extension for LB/LH/LW/LBU/LHU.
- Returns the result after a programmable access latency over a second valid/ready handshake.
- Flags misaligned, out-of-range and illegal-funct3 accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the internal array.
- BASE_ADDR, 32'h01000000: byte address of word 0. Same base as the instruction memory.
- LATENCY, 2: cycles from request acceptance to rsp_valid. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load (MemRW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_funct3  in  3  RV32I funct3 of the load/store
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access rejected

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are not reset.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: latch we/addr/wdata/funct3, load counter with LATENCY-1, go to BUSY.
  - Special case LATENCY=1: go directly to RESP, evaluate the access at that edge, and skip BUSY.
- BUSY:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 0 at an edge: evaluate the access at that edge, load rsp_*, go to RESP.
- Latency: rsp_valid rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - req_ready=0.
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - Then go to IDLE; req_ready=1 from the next cycle.
  - No request is accepted in the same cycle as the response handshake, so the minimum request-to-request period is LATENCY+1 cycles.
- Offset: off = req_addr - BASE_ADDR, 32-bit unsigned, wraps.
- Error conditions, any one sets rsp_err=1:
  - off >= DEPTH_WORDS*4 (addresses below BASE_ADDR wrap high and fail).
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
- On error: no array write, rsp_rdata=0.
- Stores: SB/SH/SW write only the addressed byte lane(s) of word off[..:2], little-endian, using req_wdata[7:0] / [15:0] / [31:0].
  - The write commits at the evaluating edge, not at acceptance.
  - rsp_rdata=0.
- Loads: read the word, select the lane by off[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns the word unchanged.
- Input handling: request inputs are ignored outside IDLE; the latched copy is used.
- Reset mid-operation: state returns to IDLE immediately. A store accepted but not yet evaluated is discarded and the array is unchanged. A pending response is dropped.
- Simultaneity: rsp_ready while rsp_valid=0 has no effect. req_valid held across RESP is accepted only once back in IDLE.

Test Plan:
- LATENCY=2, SW addr 0x01000010 data 0xDEADBEEF, then LW same addr -> store response rsp_valid exactly 2 cycles after acceptance, rsp_rdata=0, err=0; load returns 0xDEADBEEF.
- After word 0x01000010 = 0xDEADBEEF:
  - LB @0x01000013 -> 0xFFFFFFDE
  - LBU @0x01000013 -> 0x000000DE
  - LH @0x01000010 -> 0xFFFFBEEF
  - LHU @0x01000012 -> 0x0000DEAD
- SB 0x55 @0x01000011 onto 0xDEADBEEF, then LW -> 0xDEAD55EF; other lanes untouched.
- Errors, each -> rsp_err=1, rsp_rdata=0, array unchanged:
  - LW @0x01000002
  - SH @0x01000001
  - LW @0x00FFFFFC
  - LW @BASE_ADDR+4*DEPTH_WORDS
  - load funct3=011
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout. rsp_ready=1 -> req_ready=1 the following cycle, next request accepted.
- Assert rst_n=0 one cycle after accepting SW 0x12345678 @0x01000020 (LATENCY=3); release; LW @0x01000020 -> returns the prior contents, outputs at reset values during reset.
